// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : pipeline memory stage.
//
// Non-memory instructions are forwarded to writeback one cycle after they
// arrive. Loads and stores issue a single data-memory request and hold it until
// the memory acknowledges, or until TIMEOUT cycles pass without an
// acknowledgement. The stage stalls upstream for the whole access.
//
// Parameters
//   TIMEOUT      cycles an access may wait for dmem_ack before abort (1..65535)
//
// Ports
//   clk, rst_n             clock (rising edge), async active-low reset
//   ex_valid/opcode/...    EX-stage result, destination and store data
//   mem_stall              upstream must hold its EX outputs while high
//   dmem_req/we/addr/wdata data-memory request, stable until acknowledged
//   dmem_ack/rdata         single-cycle completion pulse with read data
//   wb_valid/data/rd/...   writeback entry, wb_valid is a one-cycle pulse
//   mem_err                one-cycle pulse when an access times out
// -----------------------------------------------------------------------------
`ifndef LW
`define LW  8'h10
`endif
`ifndef LW1
`define LW1 8'h11
`endif
`ifndef SW
`define SW  8'h12
`endif

module mem_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [7:0]  ex_opcode,
    input  logic [15:0] ex_result,
    input  logic [15:0] ex_wdata,
    input  logic [3:0]  ex_rd,
    input  logic        ex_regwrite,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [15:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic        wb_valid,
    output logic [15:0] wb_data,
    output logic [3:0]  wb_rd,
    output logic        wb_regwrite,
    output logic        mem_err
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    // Count value seen in the last permitted waiting cycle: the access aborts
    // after exactly TIMEOUT cycles with dmem_req high and no acknowledgement.
    localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q,       state_d;
    logic [15:0] wait_cnt_q,    wait_cnt_d;
    logic        mem_stall_q,   mem_stall_d;
    logic        dmem_req_q,    dmem_req_d;
    logic        dmem_we_q,     dmem_we_d;
    logic [15:0] dmem_addr_q,   dmem_addr_d;
    logic [15:0] dmem_wdata_q,  dmem_wdata_d;
    logic [3:0]  pend_rd_q,     pend_rd_d;
    logic        pend_rw_q,     pend_rw_d;
    logic        wb_valid_q,    wb_valid_d;
    logic [15:0] wb_data_q,     wb_data_d;
    logic [3:0]  wb_rd_q,       wb_rd_d;
    logic        wb_regwrite_q, wb_regwrite_d;
    logic        mem_err_q,     mem_err_d;

    logic        is_mem_s;
    logic        is_store_s;

    assign is_store_s = (ex_opcode == `SW);
    assign is_mem_s   = (ex_opcode == `LW) || (ex_opcode == `LW1) || is_store_s;

    // Next-state and next-output computation for the two-state access FSM.
    always_comb begin
        state_d       = state_q;
        wait_cnt_d    = wait_cnt_q;
        dmem_req_d    = dmem_req_q;
        dmem_we_d     = dmem_we_q;
        dmem_addr_d   = dmem_addr_q;
        dmem_wdata_d  = dmem_wdata_q;
        pend_rd_d     = pend_rd_q;
        pend_rw_d     = pend_rw_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        mem_err_d     = 1'b0;

        case (state_q)
            IDLE: begin
                if (ex_valid && is_mem_s) begin
                    state_d      = ACCESS;
                    wait_cnt_d   = 16'h0000;
                    dmem_req_d   = 1'b1;
                    dmem_we_d    = is_store_s;
                    dmem_addr_d  = ex_result;
                    dmem_wdata_d = ex_wdata;
                    // Destination is parked here so the visible wb_* fields
                    // keep their previous values until the access retires.
                    pend_rd_d    = ex_rd;
                    pend_rw_d    = ex_regwrite;
                end else if (ex_valid) begin
                    wb_valid_d    = 1'b1;
                    wb_data_d     = ex_result;
                    wb_rd_d       = ex_rd;
                    wb_regwrite_d = ex_regwrite;
                end else begin
                    state_d = IDLE;
                end
            end
            ACCESS: begin
                // An acknowledgement wins over a timeout in the same cycle.
                if (dmem_ack) begin
                    state_d       = IDLE;
                    dmem_req_d    = 1'b0;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = pend_rd_q;
                    wb_data_d     = dmem_we_q ? dmem_addr_q : dmem_rdata;
                    wb_regwrite_d = dmem_we_q ? 1'b0 : pend_rw_q;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d       = IDLE;
                    wait_cnt_d    = wait_cnt_q + 16'h0001;
                    dmem_req_d    = 1'b0;
                    mem_err_d     = 1'b1;
                    wb_valid_d    = 1'b1;
                    wb_rd_d       = pend_rd_q;
                    wb_data_d     = 16'h0000;
                    wb_regwrite_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 16'h0001;
                end
            end
            default: begin
                state_d    = IDLE;
                dmem_req_d = 1'b0;
            end
        endcase

        mem_stall_d = (state_d == ACCESS);
    end

    // State and output registers; reset clears everything without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            wait_cnt_q    <= 16'h0000;
            mem_stall_q   <= 1'b0;
            dmem_req_q    <= 1'b0;
            dmem_we_q     <= 1'b0;
            dmem_addr_q   <= 16'h0000;
            dmem_wdata_q  <= 16'h0000;
            pend_rd_q     <= 4'h0;
            pend_rw_q     <= 1'b0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= 16'h0000;
            wb_rd_q       <= 4'h0;
            wb_regwrite_q <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            mem_stall_q   <= mem_stall_d;
            dmem_req_q    <= dmem_req_d;
            dmem_we_q     <= dmem_we_d;
            dmem_addr_q   <= dmem_addr_d;
            dmem_wdata_q  <= dmem_wdata_d;
            pend_rd_q     <= pend_rd_d;
            pend_rw_q     <= pend_rw_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign mem_stall   = mem_stall_q;
    assign dmem_req    = dmem_req_q;
    assign dmem_we     = dmem_we_q;
    assign dmem_addr   = dmem_addr_q;
    assign dmem_wdata  = dmem_wdata_q;
    assign wb_valid    = wb_valid_q;
    assign wb_data     = wb_data_q;
    assign wb_rd       = wb_rd_q;
    assign wb_regwrite = wb_regwrite_q;
    assign mem_err     = mem_err_q;

endmodule

// File: tb/tb_mem_stage.sv
// -----------------------------------------------------------------------------
// tb_mem_stage : scoreboard bench for mem_stage (TIMEOUT = 4).
// Expected writeback entries are queued as instructions are driven and are
// compared by a monitor whenever wb_valid is seen.
// -----------------------------------------------------------------------------
`ifndef LW
`define LW  8'h10
`endif
`ifndef LW1
`define LW1 8'h11
`endif
`ifndef SW
`define SW  8'h12
`endif
`ifndef ADD
`define ADD 8'h01
`endif
`ifndef OR
`define OR  8'h02
`endif

module tb_mem_stage;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ex_valid;
    logic [7:0]  ex_opcode;
    logic [15:0] ex_result;
    logic [15:0] ex_wdata;
    logic [3:0]  ex_rd;
    logic        ex_regwrite;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [15:0] dmem_addr;
    logic [15:0] dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        wb_valid;
    logic [15:0] wb_data;
    logic [3:0]  wb_rd;
    logic        wb_regwrite;
    logic        mem_err;

    typedef struct {
        logic [15:0] data;
        logic [3:0]  rd;
        logic        rw;
        logic        err;
    } exp_t;

    exp_t        exp_q[$];
    int          wb_cyc[$];
    int          n_total = 0;
    int          n_bad   = 0;
    int          cyc_n   = 0;
    logic [15:0] last_data = 16'h0000;
    logic [3:0]  last_rd   = 4'h0;
    logic        last_rw   = 1'b0;

    mem_stage #(.TIMEOUT(TMO)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_result(ex_result),
        .ex_wdata(ex_wdata), .ex_rd(ex_rd), .ex_regwrite(ex_regwrite),
        .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_regwrite(wb_regwrite), .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts and reports mismatches.
    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Writeback monitor: pops the scoreboard on wb_valid, checks quiet cycles otherwise.
    always @(negedge clk) begin
        exp_t e;
        cyc_n++;
        if (!rst_n) begin
            last_data = 16'h0000;
            last_rd   = 4'h0;
            last_rw   = 1'b0;
        end else if (wb_valid) begin
            wb_cyc.push_back(cyc_n);
            if (exp_q.size() == 0) begin
                check_eq("wb_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check_eq("wb_data", 32'(wb_data), 32'(e.data));
                check_eq("wb_rd", 32'(wb_rd), 32'(e.rd));
                check_eq("wb_regwrite", 32'(wb_regwrite), 32'(e.rw));
                check_eq("mem_err", 32'(mem_err), 32'(e.err));
                last_data = e.data;
                last_rd   = e.rd;
                last_rw   = e.rw;
            end
        end else begin
            check_eq("mem_err_quiet", 32'(mem_err), 32'd0);
            check_eq("wb_hold_data", 32'(wb_data), 32'(last_data));
            check_eq("wb_hold_rd", 32'(wb_rd), 32'(last_rd));
            check_eq("wb_hold_rw", 32'(wb_regwrite), 32'(last_rw));
        end
    end

    task automatic push_exp(input logic [15:0] d, input logic [3:0] rd, input logic rw, input logic err);
        exp_t e;
        e.data = d; e.rd = rd; e.rw = rw; e.err = err;
        exp_q.push_back(e);
    endtask

    task automatic drive_ex(input logic [7:0] op, input logic [15:0] res, input logic [15:0] wd,
                            input logic [3:0] rd, input logic rw);
        ex_valid = 1'b1; ex_opcode = op; ex_result = res;
        ex_wdata = wd; ex_rd = rd; ex_regwrite = rw;
    endtask

    // One pass-through op: one cycle to writeback, no memory request.
    task automatic do_alu(input logic [7:0] op, input logic [15:0] res, input logic [3:0] rd, input logic rw);
        push_exp(res, rd, rw, 1'b0);
        drive_ex(op, res, 16'h0000, rd, rw);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        @(negedge clk);
        check_eq("alu_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("alu_no_req", 32'(dmem_req), 32'd0);
        @(posedge clk); #1;
    endtask

    // One memory op; ack_k = ACCESS cycle carrying the ack, 0 = never (timeout).
    task automatic do_mem(input logic [7:0] op, input logic [15:0] addr, input logic [15:0] wd,
                          input logic [3:0] rd, input logic rw, input int ack_k, input logic [15:0] rdata);
        int   limit;
        int   reqn;
        logic st;
        st    = (op == `SW);
        limit = (ack_k > 0) ? ack_k : TMO;
        if (ack_k > 0) push_exp(st ? addr : rdata, rd, st ? 1'b0 : rw, 1'b0);
        else           push_exp(16'h0000, rd, 1'b0, 1'b1);
        drive_ex(op, addr, wd, rd, rw);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        reqn = 0;
        for (int k = 1; k <= limit; k++) begin
            dmem_ack   = (k == ack_k);
            dmem_rdata = (k == ack_k) ? rdata : 16'hDEAD;
            @(negedge clk);
            if (dmem_req) reqn++;
            check_eq("acc_addr", 32'(dmem_addr), 32'(addr));
            check_eq("acc_we", 32'(dmem_we), 32'(st));
            check_eq("acc_wdata", 32'(dmem_wdata), 32'(wd));
            check_eq("acc_stall", 32'(mem_stall), 32'd1);
            @(posedge clk); #1;
            dmem_ack = 1'b0;
        end
        check_eq("req_cycles", 32'(reqn), 32'(limit));
        @(negedge clk);
        check_eq("done_req", 32'(dmem_req), 32'd0);
        check_eq("done_stall", 32'(mem_stall), 32'd0);
        check_eq("done_wb_valid", 32'(wb_valid), 32'd1);
        check_eq("done_err", 32'(mem_err), (ack_k == 0) ? 32'd1 : 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int c1, c2;
        rst_n = 1'b0; ex_valid = 1'b0; ex_opcode = 8'h00; ex_result = 16'h0000;
        ex_wdata = 16'h0000; ex_rd = 4'h0; ex_regwrite = 1'b0;
        dmem_ack = 1'b0; dmem_rdata = 16'h0000;

        // Reset values.
        #12;
        check_eq("rst_req", 32'(dmem_req), 32'd0);
        check_eq("rst_stall", 32'(mem_stall), 32'd0);
        check_eq("rst_wb_valid", 32'(wb_valid), 32'd0);
        check_eq("rst_err", 32'(mem_err), 32'd0);
        check_eq("rst_addr", 32'(dmem_addr), 32'd0);
        check_eq("rst_wb_data", 32'(wb_data), 32'd0);

        // Release between edges; the very next edge accepts an ADD.
        #10;
        rst_n = 1'b1;
        do_alu(`ADD, 16'h1234, 4'd3, 1'b1);
        do_alu(`OR,  16'hFFFF, 4'd15, 1'b0);

        do_mem(`LW,  16'h0040, 16'h0000, 4'd5, 1'b1, 3, 16'hBEEF);
        do_mem(`LW1, 16'h0123, 16'h7777, 4'd7, 1'b1, 1, 16'h5A5A);
        do_mem(`SW,  16'h0010, 16'hA5A5, 4'd9, 1'b1, 1, 16'h0000);
        do_mem(`LW,  16'h0200, 16'h0000, 4'd4, 1'b1, 0, 16'h0000);
        do_mem(`LW,  16'hFFFF, 16'h0000, 4'd2, 1'b1, TMO, 16'h1357);
        do_mem(`SW,  16'h8000, 16'h0F0F, 4'd6, 1'b0, 0, 16'h0000);

        // Ack while idle is ignored.
        dmem_ack = 1'b1; dmem_rdata = 16'hCAFE;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(negedge clk);
        check_eq("idle_ack_wb", 32'(wb_valid), 32'd0);
        check_eq("idle_ack_stall", 32'(mem_stall), 32'd0);
        @(posedge clk); #1;

        // Back-to-back: LW then OR held through the stall.
        push_exp(16'h4242, 4'd1, 1'b1, 1'b0);
        push_exp(16'h00F0, 4'd8, 1'b1, 1'b0);
        drive_ex(`LW, 16'h0050, 16'h0000, 4'd1, 1'b1);
        @(posedge clk); #1;
        drive_ex(`OR, 16'h00F0, 16'h0000, 4'd8, 1'b1);
        @(posedge clk); #1;
        dmem_ack = 1'b1; dmem_rdata = 16'h4242;
        @(posedge clk); #1;
        dmem_ack = 1'b0;
        @(posedge clk); #1;
        ex_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        if (wb_cyc.size() >= 2) begin
            c1 = wb_cyc[wb_cyc.size() - 2];
            c2 = wb_cyc[wb_cyc.size() - 1];
            check_eq("b2b_gap", 32'(c2 - c1), 32'd1);
        end else begin
            check_eq("b2b_wb_count", 32'(wb_cyc.size()), 32'd2);
        end

        // Asynchronous reset in the middle of an access.
        drive_ex(`SW, 16'h0300, 16'h1111, 4'd3, 1'b0);
        @(posedge clk); #1;
        ex_valid = 1'b0;
        check_eq("mid_req_before", 32'(dmem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("mid_req_drop", 32'(dmem_req), 32'd0);
        check_eq("mid_stall_drop", 32'(mem_stall), 32'd0);
        check_eq("mid_wb_valid", 32'(wb_valid), 32'd0);
        @(posedge clk); #3;
        rst_n = 1'b1;
        do_alu(`ADD, 16'h0BAD, 4'd11, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
MEM_STAGE -- requirements
Module: mem_stage

Interface
REQ-001 The block SHALL have one parameter: TIMEOUT, default 255, meaning the maximum number of cycles an access waits for dmem_ack before it is aborted (range 1..65535).
REQ-002 The block SHALL have these ports, one per line as name, direction, width, meaning:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
ex_valid  in  1  EX result present this cycle
ex_opcode  in  8  instruction opcode, encoded with the constants.v macros
ex_result  in  16  ALU result; this is the address for memory ops
ex_wdata  in  16  store data
ex_rd  in  4  destination register
ex_regwrite  in  1  instruction writes a register
mem_stall  out  1  upstream SHALL hold its EX outputs while high
dmem_req  out  1  data memory request
dmem_we  out  1  1 = write, 0 = read
dmem_addr  out  16  memory address
dmem_wdata  out  16  write data
dmem_ack  in  1  memory completion, single-cycle pulse
dmem_rdata  in  16  read data, valid when dmem_ack is high
wb_valid  out  1  writeback entry valid, one-cycle pulse
wb_data  out  16  writeback value
wb_rd  out  4  writeback destination register
wb_regwrite  out  1  register write enable
mem_err  out  1  one-cycle pulse marking an access timeout

Function
REQ-003 A memory op SHALL be ex_opcode equal to `LW or `LW1 (load) or `SW (store); every other opcode SHALL be a pass-through op.
REQ-004 The FSM SHALL have two states, IDLE and ACCESS; all outputs SHALL be registered.
REQ-005 In IDLE with ex_valid and a pass-through op, the next edge SHALL set wb_valid=1, wb_data=ex_result, wb_rd=ex_rd and wb_regwrite=ex_regwrite, which is a latency of 1.
REQ-006 In IDLE with ex_valid and a memory op, the next edge SHALL move the FSM to ACCESS and latch the following:
- dmem_addr=ex_result;
- dmem_wdata=ex_wdata;
- dmem_we=1 for `SW, otherwise 0;
- wb_rd and wb_regwrite;
- dmem_req=1.
REQ-007 mem_stall SHALL equal (state==ACCESS), and SHALL be driven from a register.
REQ-008 In ACCESS, dmem_req, dmem_we, dmem_addr and dmem_wdata SHALL stay stable until the cycle in which dmem_ack is sampled high.
REQ-009 When ACCESS samples dmem_ack=1, the next edge SHALL:
- clear dmem_req;
- return the FSM to IDLE;
- pulse wb_valid;
- set wb_data=dmem_rdata for a load, or wb_data=dmem_addr with wb_regwrite=0 for a store.
REQ-010 In the IDLE cycle after an ACCESS, the block SHALL accept an instruction; a load with an ack on cycle k of ACCESS SHALL therefore have wb_valid at accept+k+1.
REQ-011 dmem_ack sampled in IDLE SHALL be ignored.
REQ-012 A 16-bit wait counter SHALL clear on entry to ACCESS and increment every ACCESS cycle without ack.
REQ-013 When the counter reaches TIMEOUT without an ack, the next edge SHALL:
- return the FSM to IDLE;
- clear dmem_req;
- pulse mem_err;
- pulse wb_valid with wb_regwrite=0 and wb_data=16'h0000.
REQ-014 If dmem_ack arrives in the same cycle that the counter reaches TIMEOUT, the ack SHALL win and mem_err SHALL stay 0.
REQ-015 wb_valid and mem_err SHALL be 0 in every cycle not named in REQ-005, REQ-009 and REQ-013.
REQ-016 wb_data, wb_rd and wb_regwrite SHALL hold their last values while wb_valid=0.
REQ-017 The block SHALL apply no arithmetic to addresses; the address width is 16 bits, with no wrap or truncation.

Reset
REQ-018 While rst_n=0, all outputs SHALL be 0 and the state SHALL be IDLE, with the clock not required.
REQ-019 The wait counter SHALL reset to 0.
REQ-020 Reset asserted during ACCESS SHALL drop dmem_req and mem_stall immediately, produce no wb_valid, and discard the in-flight access.
REQ-021 On the first edge after rst_n rises, the block SHALL be able to accept ex_valid.

Verification
REQ-022 Pass-through: ADD with ex_result=16'h1234 and rd=3 -> next cycle wb_valid=1, wb_data=16'h1234, wb_rd=3, wb_regwrite=1, and dmem_req stays 0.
REQ-023 Load: LW with addr=16'h0040 and ack after 3 ACCESS cycles with rdata=16'hBEEF -> dmem_req is high for 3 cycles with addr=16'h0040 and we=0, mem_stall is high for 3 cycles, then wb_data=16'hBEEF.
REQ-024 Store: SW with addr=16'h0010, wdata=16'hA5A5 and immediate ack -> dmem_we=1, dmem_wdata=16'hA5A5 for 1 cycle, then wb_valid=1 with wb_regwrite=0.
REQ-025 Timeout: TIMEOUT=4 and no ack -> dmem_req is high for exactly 4 cycles, then mem_err=1 and wb_valid=1 with wb_regwrite=0 for 1 cycle; the same run with ack on cycle 4 -> normal completion and mem_err=0.
REQ-026 Back-to-back: LW with rd=1, then OR held on ex during the stall -> both retire in order, with the OR wb exactly 1 cycle after the LW wb.
REQ-027 Reset mid-ACCESS: rst_n=0 asynchronously between edges -> dmem_req and mem_stall drop at once; after release, ex_valid ADD retires normally and no stale wb occurs.
